branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-side partner of the execute-stage branch controller: predicts at fetch whether a conditional branch is taken and where it goes, then takes the resolved outcome from execute and flags mispredictions. Uses a direct-mapped table of 2-bit saturating counters plus a tagless target buffer. A registered one-cycle `mispredict`/`redirect_pc` pair drives PC selection and pipeline flush.

## Interface
- `WIDTH`, 32, address/data width
- `ENTRIES`, 64, table depth; power of two, ≥4
- `CNT_W`, 16, width of the misprediction statistics counter
- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `f_valid` in 1 — fetch slot holds an instruction
- `f_pc` in WIDTH — fetch PC
- `f_is_branch` in 1 — predecode: opcode is conditional branch
- `pred_taken` out 1 — combinational prediction for the fetch slot
- `pred_target` out WIDTH — combinational predicted target
- `e_valid` in 1 — execute slot holds a valid instruction
- `e_branch` in 1 — execute instruction is a conditional branch
- `e_pc` in WIDTH — PC of the execute instruction
- `e_func3` in 3 — branch funct3
- `e_zero` in 1 — comparator flag from ALU
- `e_target` in WIDTH — computed branch target
- `e_pred_taken` in 1 — prediction carried down the pipe
- `e_pred_target` in WIDTH — predicted target carried down the pipe
- `mispredict` out 1 — registered; redirect fetch and flush younger stages
- `redirect_pc` out WIDTH — registered corrected PC
- `mispredict_count` out CNT_W — saturating misprediction count

## Operation
- Index: `idx = pc[$clog2(ENTRIES)+1:2]`. The same rule applies to `f_pc` and `e_pc`.
- Per-entry state: 2-bit counter `ctr` (SNT=00, WNT=01, WT=10, ST=11), `valid` bit, and `target`.
- Lookup (combinational):
  - `pred_taken = f_valid & f_is_branch & valid[idx] & ctr[idx][1]`.
  - `pred_target = target[idx]` when `pred_taken`, else `f_pc+4`.
- Actual outcome, decoded from `e_func3`:
  - 000, 101, 111: taken iff `e_zero=1`.
  - 001, 100, 110: taken iff `e_zero=0`.
  - 010, 011: never taken.
- A resolve event occurs when `e_valid & e_branch`. On each resolve event:
  - `ctr` saturating-increments if taken and saturating-decrements if not taken.
  - If taken: `valid←1` and `target←e_target`.
  - If not taken: `valid` and `target` are unchanged.
- Mispredict condition: `actual ≠ e_pred_taken`, or (`actual & e_pred_taken & e_target ≠ e_pred_target`).
- On the clock edge after a resolve event:
  - `mispredict` is set to the mispredict condition.
  - `redirect_pc` is set to `e_target` if taken, else `e_pc+4`.
- With no resolve event, `mispredict←0` and `redirect_pc` holds its value.
- `mispredict_count` increments on each cycle `mispredict=1` and saturates at all-ones; it does not wrap.
- Arithmetic: `pc+4` is modulo 2^WIDTH; `0xFFFFFFFC+4 = 0`.

## Timing
- Reset (async assert, sync release):
  - Every `ctr←WNT`, `valid←0`, `target←0`.
  - `mispredict←0`, `redirect_pc←0`, `mispredict_count←0`.
  - `pred_taken` is 0 while in reset.
- Lookup latency is 0 cycles. Mispredict latency is 1 cycle after the resolve cycle.
- A table write lands at the end of the resolve cycle and is visible to fetch on the next cycle.
- Same-cycle fetch and resolve to the same `idx`: fetch sees the old entry. No bypass.
- Back-to-back resolves on consecutive cycles are each fully processed. `mispredict` may stay high for consecutive cycles.
- Reset asserted mid-operation discards any pending mispredict. No redirect is issued after release.
- `e_branch` with `e_valid=0` is ignored: no update and no mispredict.

## Structure
- Shared package `branch_pkg` holds:
  - The funct3 localparams (BEQ, BNE, BLT, BGE, BLTU, BGEU).
  - The `ctr_t` enum {SNT, WNT, WT, ST}.
  - A function `branch_taken(func3, zero)`, also usable by the branch controller.
- One sub-module, `sat_ctr2`: a 2-bit saturating up/down next-state block, instantiated in the update path.
- Table storage is flop arrays inside `branch_predictor`, so that async reset clears every entry.

## Test plan
- **Reset state:** release reset; fetch `f_pc=0x100`, `f_is_branch=1` → `pred_taken=0`, `pred_target=0x104`; `mispredict_count=0`.
- **First taken branch:** resolve BEQ at `e_pc=0x100`, `e_zero=1`, `e_target=0x80`, `e_pred_taken=0` → next cycle `mispredict=1`, `redirect_pc=0x80`, count=1. Then fetch 0x100 → `pred_taken=1`, `pred_target=0x80`.
- **Counter saturation:** resolve BNE at 0x200, `e_zero=0`, five times → ctr=ST. Then two not-taken resolves → ctr=WNT and `pred_taken=0`. Each direction flip is flagged only when it differs from `e_pred_taken`.
- **Target mismatch:** BGEU at 0x300, `e_zero=1`, predicted taken with `e_pred_target=0x400`, actual `e_target=0x500` → `mispredict=1`, `redirect_pc=0x500`; entry target is updated to 0x500.
- **Same-cycle collision:** resolve a taken branch at `idx=3` while fetching the same idx → fetch shows the old (invalid) prediction; the next cycle shows `pred_taken=1`.
- **Edge cases:**
  - Drive `mispredict` 2^CNT_W+2 times → count stays 0xFFFF.
  - Assert `rst_n` low in the cycle after a resolve → `mispredict` goes to 0 immediately and every table entry reads WNT/invalid.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared branch definitions for the fetch-side predictor and the execute-side
// branch controller.
//   - funct3 encodings of the conditional branches
//   - ctr_t : 2-bit saturating counter states
//   - branch_taken(func3, zero) : resolved direction from funct3 and the ALU
//     comparator flag
package branch_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    // The ALU zero flag means "equal" for BEQ/BNE and "comparison false" for
    // the less-than family, so BGE/BGEU share BEQ's polarity.
    // Undefined encodings (010, 011) never branch.
    function automatic logic branch_taken(input logic [2:0] func3, input logic zero);
        logic taken_s;
        case (func3)
            BEQ, BGE, BGEU: taken_s = zero;
            BNE, BLT, BLTU: taken_s = ~zero;
            default:        taken_s = 1'b0;
        endcase
        return taken_s;
    endfunction

endpackage

// File: rtl/sat_ctr2.sv
// 2-bit saturating up/down counter, next-state logic only.
//   ctr_cur  in  2 : current counter value
//   taken    in  1 : 1 = count up (towards ST), 0 = count down (towards SNT)
//   ctr_next out 2 : next counter value, clamped at SNT and ST
module sat_ctr2
    import branch_pkg::*;
(
    input  logic [1:0] ctr_cur,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    // Saturating increment/decrement of the counter state
    always_comb begin
        ctr_next = ctr_cur;
        if (taken) begin
            if (ctr_cur != ST) begin
                ctr_next = ctr_cur + 2'd1;
            end else begin
                ctr_next = ctr_cur;
            end
        end else begin
            if (ctr_cur != SNT) begin
                ctr_next = ctr_cur - 2'd1;
            end else begin
                ctr_next = ctr_cur;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped 2-bit counter table plus tagless
// target buffer, updated from the execute stage, with a registered
// mispredict/redirect pair for PC selection and flush.
//   clk, rst_n                 : clock, async active-low reset
//   f_valid, f_pc, f_is_branch : fetch slot lookup request
//   pred_taken, pred_target    : combinational prediction for the fetch slot
//   e_valid, e_branch, e_pc, e_func3, e_zero, e_target,
//   e_pred_taken, e_pred_target: resolved branch from execute
//   mispredict, redirect_pc    : registered redirect, one cycle after resolve
//   mispredict_count           : saturating count of mispredict cycles
module branch_predictor
    import branch_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f_valid,
    input  logic [WIDTH-1:0] f_pc,
    input  logic             f_is_branch,
    output logic             pred_taken,
    output logic [WIDTH-1:0] pred_target,
    input  logic             e_valid,
    input  logic             e_branch,
    input  logic [WIDTH-1:0] e_pc,
    input  logic [2:0]       e_func3,
    input  logic             e_zero,
    input  logic [WIDTH-1:0] e_target,
    input  logic             e_pred_taken,
    input  logic [WIDTH-1:0] e_pred_target,
    output logic             mispredict,
    output logic [WIDTH-1:0] redirect_pc,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int               IDX_W   = $clog2(ENTRIES);
    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(3'd4);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Table storage is kept in flops so the async reset clears every entry.
    logic [1:0]       ctr_r    [ENTRIES];
    logic [ENTRIES-1:0] valid_r;
    logic [WIDTH-1:0] target_r [ENTRIES];

    logic [IDX_W-1:0] f_idx_s;
    logic [IDX_W-1:0] e_idx_s;
    logic             resolve_s;
    logic             actual_s;
    logic             mp_cond_s;
    logic [WIDTH-1:0] redirect_next_s;
    logic [1:0]       ctr_next_s;

    assign f_idx_s = f_pc[IDX_W+1:2];
    assign e_idx_s = e_pc[IDX_W+1:2];

    // Fetch lookup: reads the table as it stood before any same-cycle update
    always_comb begin
        pred_taken = f_valid & f_is_branch & valid_r[f_idx_s] & ctr_r[f_idx_s][1];
        if (pred_taken) begin
            pred_target = target_r[f_idx_s];
        end else begin
            pred_target = f_pc + PC_STEP;
        end
    end

    // Execute-side resolution: actual direction, mispredict test, redirect PC
    always_comb begin
        resolve_s = e_valid & e_branch;
        actual_s  = branch_taken(e_func3, e_zero);
        mp_cond_s = (actual_s != e_pred_taken) |
                    (actual_s & e_pred_taken & (e_target != e_pred_target));
        if (actual_s) begin
            redirect_next_s = e_target;
        end else begin
            redirect_next_s = e_pc + PC_STEP;
        end
    end

    sat_ctr2 u_sat_ctr2 (
        .ctr_cur  (ctr_r[e_idx_s]),
        .taken    (actual_s),
        .ctr_next (ctr_next_s)
    );

    // Table update on resolve; a not-taken outcome leaves valid/target alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_r[i]    <= WNT;
                target_r[i] <= {WIDTH{1'b0}};
            end
            valid_r <= {ENTRIES{1'b0}};
        end else if (resolve_s) begin
            ctr_r[e_idx_s] <= ctr_next_s;
            if (actual_s) begin
                valid_r[e_idx_s]  <= 1'b1;
                target_r[e_idx_s] <= e_target;
            end else begin
                valid_r[e_idx_s]  <= valid_r[e_idx_s];
                target_r[e_idx_s] <= target_r[e_idx_s];
            end
        end else begin
            valid_r <= valid_r;
        end
    end

    // Registered redirect and statistics; the count steps on the same edge
    // that raises mispredict so it already includes the current redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict       <= 1'b0;
            redirect_pc      <= {WIDTH{1'b0}};
            mispredict_count <= {CNT_W{1'b0}};
        end else begin
            if (resolve_s) begin
                mispredict  <= mp_cond_s;
                redirect_pc <= redirect_next_s;
            end else begin
                mispredict  <= 1'b0;
                redirect_pc <= redirect_pc;
            end
            if (resolve_s && mp_cond_s && (mispredict_count != CNT_MAX)) begin
                mispredict_count <= mispredict_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                mispredict_count <= mispredict_count;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus pushes hand-computed
// expectations into queues, a monitor pops and compares on the falling edge.
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic        f_valid;
    logic [31:0] f_pc;
    logic        f_is_branch;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        e_valid;
    logic        e_branch;
    logic [31:0] e_pc;
    logic [2:0]  e_func3;
    logic        e_zero;
    logic [31:0] e_target;
    logic        e_pred_taken;
    logic [31:0] e_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [15:0] mispredict_count;

    typedef struct {
        logic        mp;
        logic [31:0] rpc;
        logic [15:0] cnt;
    } res_exp_t;

    typedef struct {
        logic        taken;
        logic [31:0] target;
    } pred_exp_t;

    res_exp_t  res_q[$];
    pred_exp_t pred_q[$];
    int        total;
    int        bad;
    logic      res_seen;

    branch_predictor #(.WIDTH(32), .ENTRIES(64), .CNT_W(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .f_valid          (f_valid),
        .f_pc             (f_pc),
        .f_is_branch      (f_is_branch),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .e_valid          (e_valid),
        .e_branch         (e_branch),
        .e_pc             (e_pc),
        .e_func3          (e_func3),
        .e_zero           (e_zero),
        .e_target         (e_target),
        .e_pred_taken     (e_pred_taken),
        .e_pred_target    (e_pred_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: a resolve sampled at a rising edge is checked at the next falling edge
    always @(posedge clk) res_seen <= e_valid & e_branch;

    always @(negedge clk) begin
        res_exp_t  re;
        pred_exp_t pe;
        if (res_seen) begin
            if (res_q.size() == 0) begin
                chk("res_q_underflow", 32'd1, 32'd0);
            end else begin
                re = res_q.pop_front();
                chk("mispredict", {31'd0, mispredict}, {31'd0, re.mp});
                chk("redirect_pc", redirect_pc, re.rpc);
                chk("mp_count", {16'd0, mispredict_count}, {16'd0, re.cnt});
            end
        end else begin
            chk("mp_idle", {31'd0, mispredict}, 32'd0);
        end
        if (f_valid) begin
            if (pred_q.size() == 0) begin
                chk("pred_q_underflow", 32'd1, 32'd0);
            end else begin
                pe = pred_q.pop_front();
                chk("pred_taken", {31'd0, pred_taken}, {31'd0, pe.taken});
                chk("pred_target", pred_target, pe.target);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        e_valid = 1'b0;
        e_branch = 1'b0;
        f_valid = 1'b0;
        f_is_branch = 1'b0;
    endtask

    task automatic set_fetch(input logic [31:0] pc, input logic br,
                             input logic exp_t, input logic [31:0] exp_tg);
        pred_exp_t pe;
        f_valid = 1'b1;
        f_pc = pc;
        f_is_branch = br;
        pe.taken = exp_t;
        pe.target = exp_tg;
        pred_q.push_back(pe);
    endtask

    task automatic fetch(input logic [31:0] pc, input logic exp_t, input logic [31:0] exp_tg);
        set_fetch(pc, 1'b1, exp_t, exp_tg);
        tick();
    endtask

    task automatic resolve(input logic [2:0] f3, input logic z, input logic [31:0] pc,
                           input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                           input logic emp, input logic [31:0] erpc, input logic [15:0] ecnt);
        res_exp_t re;
        e_valid = 1'b1;
        e_branch = 1'b1;
        e_func3 = f3;
        e_zero = z;
        e_pc = pc;
        e_target = tgt;
        e_pred_taken = ptk;
        e_pred_target = ptgt;
        re.mp = emp;
        re.rpc = erpc;
        re.cnt = ecnt;
        res_q.push_back(re);
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_cnt;
        total = 0;
        bad = 0;
        res_seen = 1'b0;
        rst_n = 1'b0;
        f_valid = 1'b0; f_pc = 32'd0; f_is_branch = 1'b0;
        e_valid = 1'b0; e_branch = 1'b0; e_pc = 32'd0; e_func3 = 3'd0; e_zero = 1'b0;
        e_target = 32'd0; e_pred_taken = 1'b0; e_pred_target = 32'd0;

        // Reset state: prediction is off during and after reset
        tick();
        fetch(32'h100, 1'b0, 32'h104);
        rst_n = 1'b1;
        tick();
        fetch(32'h100, 1'b0, 32'h104);
        chk("cnt_after_reset", {16'd0, mispredict_count}, 32'd0);

        // First taken branch
        resolve(3'b000, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80, 16'd1);
        fetch(32'h100, 1'b1, 32'h80);

        // Counter saturation on idx 0 (fresh table)
        do_reset();
        resolve(3'b001, 1'b0, 32'h200, 32'h240, 1'b0, 32'h0,   1'b1, 32'h240, 16'd1);
        resolve(3'b001, 1'b0, 32'h200, 32'h240, 1'b1, 32'h240, 1'b0, 32'h240, 16'd1);
        resolve(3'b001, 1'b0, 32'h200, 32'h240, 1'b1, 32'h240, 1'b0, 32'h240, 16'd1);
        resolve(3'b001, 1'b0, 32'h200, 32'h240, 1'b1, 32'h240, 1'b0, 32'h240, 16'd1);
        resolve(3'b001, 1'b0, 32'h200, 32'h240, 1'b1, 32'h240, 1'b0, 32'h240, 16'd1);
        fetch(32'h200, 1'b1, 32'h240);
        resolve(3'b001, 1'b1, 32'h200, 32'h240, 1'b1, 32'h240, 1'b1, 32'h204, 16'd2);
        fetch(32'h200, 1'b1, 32'h240);
        resolve(3'b001, 1'b1, 32'h200, 32'h240, 1'b1, 32'h240, 1'b1, 32'h204, 16'd3);
        resolve(3'b001, 1'b1, 32'h200, 32'h240, 1'b1, 32'h240, 1'b1, 32'h204, 16'd4);
        fetch(32'h200, 1'b0, 32'h204);

        // Target mismatch (idx 0 now SNT, valid, target 0x240)
        resolve(3'b111, 1'b1, 32'h300, 32'h500, 1'b1, 32'h400, 1'b1, 32'h500, 16'd5);
        resolve(3'b111, 1'b1, 32'h300, 32'h500, 1'b1, 32'h500, 1'b0, 32'h500, 16'd5);
        resolve(3'b111, 1'b1, 32'h300, 32'h500, 1'b1, 32'h500, 1'b0, 32'h500, 16'd5);
        fetch(32'h300, 1'b1, 32'h500);

        // funct3 decode on idx 4
        resolve(3'b100, 1'b1, 32'h10, 32'h1000, 1'b0, 32'h0,    1'b0, 32'h14,   16'd5);
        resolve(3'b101, 1'b1, 32'h10, 32'h1000, 1'b0, 32'h0,    1'b1, 32'h1000, 16'd6);
        resolve(3'b010, 1'b1, 32'h10, 32'h1000, 1'b1, 32'h1000, 1'b1, 32'h14,   16'd7);
        resolve(3'b011, 1'b0, 32'h10, 32'h3000, 1'b0, 32'h0,    1'b0, 32'h14,   16'd7);
        resolve(3'b110, 1'b0, 32'h10, 32'h2000, 1'b0, 32'h0,    1'b1, 32'h2000, 16'd8);
        resolve(3'b000, 1'b0, 32'h10, 32'h2000, 1'b0, 32'h0,    1'b0, 32'h14,   16'd8);
        fetch(32'h10, 1'b0, 32'h14);

        // pc+4 wraps to zero
        resolve(3'b010, 1'b0, 32'hFFFF_FFFC, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0, 16'd8);
        set_fetch(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        tick();

        // e_branch without e_valid is ignored (no queue entry: monitor expects idle)
        e_valid = 1'b0; e_branch = 1'b1; e_func3 = 3'b000; e_zero = 1'b1;
        e_pc = 32'h20; e_target = 32'h99; e_pred_taken = 1'b0;
        @(posedge clk); #1;
        e_branch = 1'b0;
        fetch(32'h20, 1'b0, 32'h24);
        chk("cnt_ignored", {16'd0, mispredict_count}, 32'd8);

        // Same-cycle collision at idx 3: fetch sees the old entry
        do_reset();
        set_fetch(32'hC, 1'b1, 1'b0, 32'h10);
        resolve(3'b000, 1'b1, 32'hC, 32'h700, 1'b0, 32'h0, 1'b1, 32'h700, 16'd1);
        fetch(32'hC, 1'b1, 32'h700);

        // Reset in the cycle after a resolve discards the pending mispredict
        do_reset();
        resolve(3'b000, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 16'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mp_immediate", {31'd0, mispredict}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_count", {16'd0, mispredict_count}, 32'd0);
        fetch(32'h100, 1'b0, 32'h104);
        // One taken resolve flips WNT to WT: proves the counter reset to WNT
        resolve(3'b000, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80, 16'd1);
        fetch(32'h100, 1'b1, 32'h80);
        tick();

        // Counter saturation: 2^16+2 back-to-back mispredicts
        do_reset();
        for (int i = 0; i < 65538; i++) begin
            exp_cnt = (i >= 65535) ? 16'hFFFF : 16'(i + 1);
            resolve(3'b010, 1'b0, 32'h40, 32'h0, 1'b1, 32'h0, 1'b1, 32'h44, exp_cnt);
        end
        tick();
        chk("cnt_saturated", {16'd0, mispredict_count}, 32'h0000_FFFF);
        tick();
        chk("res_q_drained", res_q.size(), 32'd0);
        chk("pred_q_drained", pred_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
